// File: rtl/dual_port_ram_be.sv
// dual_port_ram_be: true dual-port synchronous RAM with per-byte write enables.
//
// Both ports share one clock and one memory array. Each port can read or write
// one word per cycle. When both ports write the same address in the same
// cycle, port 1 wins on the bytes that both ports enable. Each such
// overlapping write raises a one-cycle collision pulse and bumps a saturating
// collision counter.
//
// Parameters
//   ADDR_WIDTH : address bits per port (DEPTH = 2**ADDR_WIDTH)
//   DATA_WIDTH : word width, a multiple of 8
//   RDW_MODE   : same-port read-during-write, 0 = no change, 1 = write-first
//   OUT_REG    : 1 adds an output register stage (read latency 2)
//   CNT_WIDTH  : collision counter width
//
// Ports
//   clk, rst_n              : clock, asynchronous active-low reset
//   en*, we*, be*, addr*    : per-port access enable, write select, byte
//                             enables and address
//   data*                   : per-port write data
//   out*, vld*              : per-port read data and read-valid strobe
//   collision               : pulse in the cycle after an overlapping write
//   collision_cnt           : saturating count of collision events
module dual_port_ram_be #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned RDW_MODE   = 0,
  parameter int unsigned OUT_REG    = 0,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en1,
  input  logic                    we1,
  input  logic [DATA_WIDTH/8-1:0] be1,
  input  logic [ADDR_WIDTH-1:0]   addr1,
  input  logic [DATA_WIDTH-1:0]   data1,
  output logic [DATA_WIDTH-1:0]   out1,
  output logic                    vld1,
  input  logic                    en2,
  input  logic                    we2,
  input  logic [DATA_WIDTH/8-1:0] be2,
  input  logic [ADDR_WIDTH-1:0]   addr2,
  input  logic [DATA_WIDTH-1:0]   data2,
  output logic [DATA_WIDTH-1:0]   out2,
  output logic                    vld2,
  output logic                    collision,
  output logic [CNT_WIDTH-1:0]    collision_cnt
);

  localparam int unsigned DEPTH     = 2 ** ADDR_WIDTH;
  localparam int unsigned NB        = DATA_WIDTH / 8;
  localparam bit          RdwFirst  = (RDW_MODE == 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Raw array read registers; no reset so the array plus these map onto block RAM.
  logic [DATA_WIDTH-1:0] ram1_q, ram2_q;

  logic                  wr1, wr2;
  logic                  mem_en;
  logic                  vld1_d, vld2_d;
  logic                  coll_d;

  // Fabric state
  logic                  vld1_s1_q, vld2_s1_q;
  logic [NB-1:0]         fwd_be1_q, fwd_be2_q;
  logic [DATA_WIDTH-1:0] fwd_data1_q, fwd_data2_q;
  logic [DATA_WIDTH-1:0] hold1_q, hold2_q;
  logic [DATA_WIDTH-1:0] merged1, merged2;
  logic                  coll_q;
  logic [CNT_WIDTH-1:0]  cnt_q;

  assign mem_en = rst_n;
  assign wr1    = en1 & we1;
  assign wr2    = en2 & we2;
  assign vld1_d = en1 & (~we1 | RdwFirst);
  assign vld2_d = en2 & (~we2 | RdwFirst);
  assign coll_d = wr1 & wr2 & (addr1 == addr2) & (|(be1 & be2));

  // Reads sample the pre-write word, so a cross-port reader sees old data.
  // Port 1 bytes are written after port 2 bytes, so port 1 wins on overlap.
  always_ff @(posedge clk) begin : mem_access
    if (mem_en) begin
      if (en1) ram1_q <= mem[addr1];
      if (en2) ram2_q <= mem[addr2];
      for (int i = 0; i < NB; i++) begin
        if (wr2 && be2[i]) mem[addr2][8*i +: 8] <= data2[8*i +: 8];
      end
      for (int i = 0; i < NB; i++) begin
        if (wr1 && be1[i]) mem[addr1][8*i +: 8] <= data1[8*i +: 8];
      end
    end
  end

  // Write-first forwarding: overlay the port's own written bytes on the old word.
  always_comb begin
    merged1 = ram1_q;
    merged2 = ram2_q;
    for (int i = 0; i < NB; i++) begin
      if (fwd_be1_q[i]) merged1[8*i +: 8] = fwd_data1_q[8*i +: 8];
      if (fwd_be2_q[i]) merged2[8*i +: 8] = fwd_data2_q[8*i +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld1_s1_q   <= 1'b0;
      vld2_s1_q   <= 1'b0;
      fwd_be1_q   <= '0;
      fwd_be2_q   <= '0;
      fwd_data1_q <= '0;
      fwd_data2_q <= '0;
      hold1_q     <= '0;
      hold2_q     <= '0;
      coll_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      vld1_s1_q <= vld1_d;
      vld2_s1_q <= vld2_d;
      fwd_be1_q <= (wr1 && RdwFirst) ? be1 : '0;
      fwd_be2_q <= (wr2 && RdwFirst) ? be2 : '0;
      if (wr1) fwd_data1_q <= data1;
      if (wr2) fwd_data2_q <= data2;
      // Last delivered word; doubles as the output register when OUT_REG=1.
      if (vld1_s1_q) hold1_q <= merged1;
      if (vld2_s1_q) hold2_q <= merged2;
      coll_q <= coll_d;
      if (coll_d && (cnt_q != {CNT_WIDTH{1'b1}})) cnt_q <= cnt_q + CNT_WIDTH'(1);
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic vld1_s2_q, vld2_s2_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld1_s2_q <= 1'b0;
        vld2_s2_q <= 1'b0;
      end else begin
        vld1_s2_q <= vld1_s1_q;
        vld2_s2_q <= vld2_s1_q;
      end
    end

    assign out1 = hold1_q;
    assign out2 = hold2_q;
    assign vld1 = vld1_s2_q;
    assign vld2 = vld2_s2_q;
  end else begin : g_no_out_reg
    // Fresh RAM word while valid, otherwise the held copy.
    assign out1 = vld1_s1_q ? merged1 : hold1_q;
    assign out2 = vld2_s1_q ? merged2 : hold2_q;
    assign vld1 = vld1_s1_q;
    assign vld2 = vld2_s1_q;
  end

  assign collision     = coll_q;
  assign collision_cnt = cnt_q;

endmodule

// File: tb/tb_dual_port_ram_be.sv
// Bench for dual_port_ram_be. Two instances share the same stimulus:
//   u_a : RDW_MODE=0, OUT_REG=0, CNT_WIDTH=2
//   u_b : RDW_MODE=1, OUT_REG=1, CNT_WIDTH=16
// A word-level memory model predicts every output of both instances.
module tb_dual_port_ram_be;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int NB = DW / 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en1 = 0, we1 = 0, en2 = 0, we2 = 0;
  logic [NB-1:0] be1 = '0, be2 = '0;
  logic [AW-1:0] addr1 = '0, addr2 = '0;
  logic [DW-1:0] data1 = '0, data2 = '0;

  logic [DW-1:0] out1_a, out2_a, out1_b, out2_b;
  logic          vld1_a, vld2_a, vld1_b, vld2_b;
  logic          coll_a, coll_b;
  logic [1:0]    cnt_a;
  logic [15:0]   cnt_b;

  always #5 clk = ~clk;

  dual_port_ram_be #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RDW_MODE(0), .OUT_REG(0), .CNT_WIDTH(2)
  ) u_a (
    .clk(clk), .rst_n(rst_n),
    .en1(en1), .we1(we1), .be1(be1), .addr1(addr1), .data1(data1),
    .out1(out1_a), .vld1(vld1_a),
    .en2(en2), .we2(we2), .be2(be2), .addr2(addr2), .data2(data2),
    .out2(out2_a), .vld2(vld2_a),
    .collision(coll_a), .collision_cnt(cnt_a)
  );

  dual_port_ram_be #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RDW_MODE(1), .OUT_REG(1), .CNT_WIDTH(16)
  ) u_b (
    .clk(clk), .rst_n(rst_n),
    .en1(en1), .we1(we1), .be1(be1), .addr1(addr1), .data1(data1),
    .out1(out1_b), .vld1(vld1_b),
    .en2(en2), .we2(we2), .be2(be2), .addr2(addr2), .data2(data2),
    .out2(out2_b), .vld2(vld2_b),
    .collision(coll_b), .collision_cnt(cnt_b)
  );

  // Reference model state
  logic [DW-1:0] mem_m [2**AW];
  logic [DW-1:0] eo_a [2], eo_b [2];
  logic          ev_a [2], ev_b [2];
  logic          pend_v [2];
  logic [DW-1:0] pend_w [2];
  logic          ec;
  int            ecnt_a, ecnt_b;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] overlay(input logic [DW-1:0] old_w,
                                            input logic [DW-1:0] new_w,
                                            input logic [NB-1:0] be);
    logic [DW-1:0] r;
    r = old_w;
    for (int i = 0; i < NB; i++) if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
    return r;
  endfunction

  task automatic check_all();
    chk("a_out1", out1_a, eo_a[0]);
    chk("a_vld1", 32'(vld1_a), 32'(ev_a[0]));
    chk("a_out2", out2_a, eo_a[1]);
    chk("a_vld2", 32'(vld2_a), 32'(ev_a[1]));
    chk("b_out1", out1_b, eo_b[0]);
    chk("b_vld1", 32'(vld1_b), 32'(ev_b[0]));
    chk("b_out2", out2_b, eo_b[1]);
    chk("b_vld2", 32'(vld2_b), 32'(ev_b[1]));
    chk("a_coll", 32'(coll_a), 32'(ec));
    chk("b_coll", 32'(coll_b), 32'(ec));
    chk("a_cnt", 32'(cnt_a), 32'(ecnt_a));
    chk("b_cnt", 32'(cnt_b), 32'(ecnt_b));
  endtask

  task automatic model_reset();
    for (int p = 0; p < 2; p++) begin
      eo_a[p] = '0; eo_b[p] = '0; ev_a[p] = 0; ev_b[p] = 0;
      pend_v[p] = 0; pend_w[p] = '0;
    end
    ec = 0; ecnt_a = 0; ecnt_b = 0;
  endtask

  // Applies current inputs across one rising edge, then checks at edge+1.
  task automatic cycle();
    logic [DW-1:0] r [2];
    logic [DW-1:0] wb [2];
    logic          c;
    logic          w1, w2;
    logic          act;
    logic [DW-1:0] nw;
    act = rst_n;
    c = 0;
    if (act) begin
      w1 = en1 && we1;
      w2 = en2 && we2;
      r[0] = mem_m[addr1];
      r[1] = mem_m[addr2];
      wb[0] = w1 ? overlay(r[0], data1, be1) : r[0];
      wb[1] = w2 ? overlay(r[1], data2, be2) : r[1];
      c = w1 && w2 && (addr1 == addr2) && ((be1 & be2) != 0);
      if (w1 && w2 && addr1 == addr2) begin
        nw = mem_m[addr1];
        for (int i = 0; i < NB; i++) begin
          if (be1[i]) nw[8*i +: 8] = data1[8*i +: 8];
          else if (be2[i]) nw[8*i +: 8] = data2[8*i +: 8];
        end
        mem_m[addr1] = nw;
      end else begin
        if (w1) mem_m[addr1] = overlay(mem_m[addr1], data1, be1);
        if (w2) mem_m[addr2] = overlay(mem_m[addr2], data2, be2);
      end
      // u_a: plain reads only, one edge of latency
      ev_a[0] = en1 && !we1;
      ev_a[1] = en2 && !we2;
      if (ev_a[0]) eo_a[0] = r[0];
      if (ev_a[1]) eo_a[1] = r[1];
    end
    @(posedge clk);
    #1;
    if (act) begin
      // u_b: reads and writes both deliver, two edges of latency
      for (int p = 0; p < 2; p++) begin
        ev_b[p] = pend_v[p];
        if (pend_v[p]) eo_b[p] = pend_w[p];
      end
      pend_v[0] = en1; pend_w[0] = wb[0];
      pend_v[1] = en2; pend_w[1] = wb[1];
      ec = c;
      if (c) begin
        ecnt_a = (ecnt_a < 3) ? ecnt_a + 1 : 3;
        ecnt_b = (ecnt_b < 65535) ? ecnt_b + 1 : 65535;
      end
    end
    check_all();
  endtask

  task automatic idle();
    en1 = 0; we1 = 0; en2 = 0; we2 = 0; be1 = '0; be2 = '0;
  endtask

  task automatic p1(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                    input logic [NB-1:0] be);
    en1 = 1; we1 = we; addr1 = a; data1 = d; be1 = be;
  endtask

  task automatic p2(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                    input logic [NB-1:0] be);
    en2 = 1; we2 = we; addr2 = a; data2 = d; be2 = be;
  endtask

  task automatic assert_reset();
    rst_n = 0;
    model_reset();
    #1;
    check_all();
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    int seq [5];
    seq = '{1, 2, 3, 3, 3};
    model_reset();
    #1;
    check_all();
    cycle();
    cycle();
    release_reset();

    // Fill the whole array so every later read has a known model value
    for (int a = 0; a < 128; a++) begin
      p1(1, AW'(a), $urandom, 4'hF);
      p2(1, AW'(a + 128), $urandom, 4'hF);
      cycle();
    end
    idle();

    // Write then cross-port readback
    p1(1, 8'h10, 32'hDEADBEEF, 4'hF); cycle(); idle();
    p2(0, 8'h10, '0, 4'h0); cycle(); idle();
    chk("tp1_out2_a", out2_a, 32'hDEADBEEF);
    chk("tp1_vld2_a", 32'(vld2_a), 32'd1);
    cycle();
    chk("tp1_out2_b", out2_b, 32'hDEADBEEF);

    // Byte enables
    p1(1, 8'h05, 32'h11223344, 4'hF); cycle();
    p1(1, 8'h05, 32'hAABBCCDD, 4'b0101); cycle();
    p1(0, 8'h05, '0, 4'h0); cycle(); idle();
    chk("tp2_be_a", out1_a, 32'h11BB33DD);
    cycle();
    chk("tp2_be_b", out1_b, 32'h11BB33DD);

    // Read-during-write on port 1, cross-port read on port 2
    p1(1, 8'h03, 32'h12345678, 4'hF); cycle(); idle(); cycle(); cycle();
    p1(1, 8'h03, 32'h0000FFFF, 4'b0011);
    p2(0, 8'h03, '0, 4'h0);
    cycle(); idle();
    chk("tp3_nochg_vld1", 32'(vld1_a), 32'd0);
    chk("tp3_nochg_out1", out1_a, 32'h11BB33DD);
    chk("tp3_cross_a", out2_a, 32'h12345678);
    cycle();
    chk("tp3_wfirst_out1", out1_b, 32'h1234FFFF);
    chk("tp3_wfirst_vld1", 32'(vld1_b), 32'd1);
    chk("tp3_cross_b", out2_b, 32'h12345678);

    // Overlapping same-address writes
    p1(1, 8'h7F, 32'h0, 4'hF); cycle(); idle();
    p1(1, 8'h7F, 32'hAAAAAAAA, 4'b0011);
    p2(1, 8'h7F, 32'h55555555, 4'b0110);
    cycle(); idle();
    chk("tp4_coll", 32'(coll_a), 32'd1);
    chk("tp4_cnt", 32'(cnt_a), 32'd1);
    p1(0, 8'h7F, '0, 4'h0); cycle(); idle();
    chk("tp4_coll_drop", 32'(coll_a), 32'd0);
    chk("tp4_word", out1_a, 32'h0055AAAA);
    p1(1, 8'h7F, 32'h01010101, 4'b0001);
    p2(1, 8'h7F, 32'h02020202, 4'b0010);
    cycle(); idle();
    chk("tp4_nocoll", 32'(coll_a), 32'd0);
    chk("tp4_nocoll_cnt", 32'(cnt_b), 32'd1);
    cycle();

    // Output-register latency, then a reset that flushes an in-flight read
    p1(0, 8'h10, '0, 4'h0); cycle(); idle();
    chk("tp5_vld_early", 32'(vld1_b), 32'd0);
    cycle();
    chk("tp5_vld_n2", 32'(vld1_b), 32'd1);
    chk("tp5_out_n2", out1_b, 32'hDEADBEEF);
    p1(0, 8'h05, '0, 4'h0); cycle();
    // Writes driven while reset is held must not land
    p1(1, 8'h05, 32'hFFFFFFFF, 4'hF);
    assert_reset();
    cycle();
    chk("tp5_flush_vld", 32'(vld1_b), 32'd0);
    chk("tp5_flush_out", out1_b, 32'd0);
    cycle();
    idle();
    release_reset();
    cycle();
    chk("tp5_post_vld", 32'(vld1_b), 32'd0);
    p1(0, 8'h05, '0, 4'h0); cycle(); idle();
    chk("tp5_nowrite", out1_a, 32'h11BB33DD);
    cycle();

    // Counter saturation on the 2-bit counter
    for (int i = 0; i < 5; i++) begin
      p1(1, 8'h40, $urandom, 4'hF);
      p2(1, 8'h40, $urandom, 4'hF);
      cycle();
      chk("tp6_cnt", 32'(cnt_a), 32'(seq[i]));
      chk("tp6_pulse", 32'(coll_a), 32'd1);
    end
    idle();
    cycle();

    // Random traffic on a small address window to provoke interactions
    for (int n = 0; n < 400; n++) begin
      en1 = 1'($urandom); we1 = 1'($urandom); be1 = NB'($urandom);
      addr1 = AW'($urandom_range(0, 7)); data1 = $urandom;
      en2 = 1'($urandom); we2 = 1'($urandom); be2 = NB'($urandom);
      addr2 = AW'($urandom_range(0, 7)); data2 = $urandom;
      cycle();
    end
    idle();
    cycle();
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
